// File: rtl/mod_addsub_ctrl_if.sv
// Start/done bus between the modular add/sub controller (master) and one
// multi-precision adder (slave).
interface mod_addsub_ctrl_if #(
    parameter int N = 512
);
    logic         add_start;
    logic         add_subtract;
    logic         add_shift;
    logic [N+1:0] add_in_a;
    logic [N+1:0] add_in_b;
    logic [N+2:0] add_result;
    logic         add_done;

    modport master (
        output add_start, add_subtract, add_shift, add_in_a, add_in_b,
        input  add_result, add_done
    );

    modport slave (
        input  add_start, add_subtract, add_shift, add_in_a, add_in_b,
        output add_result, add_done
    );
endinterface

// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract controller: r = (a +/- b) mod M using two passes through
// an external adder (raw op, then correction by M), with a per-wait timeout.
module mod_addsub_ctrl #(
    parameter int N       = 512,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     op_sub,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    input  logic [N-1:0]             in_m,
    output logic [N-1:0]             result,
    output logic                     done,
    output logic                     busy,
    output logic                     err,
    mod_addsub_ctrl_if.master        add_bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE1, S_WAIT1, S_ISSUE2, S_WAIT2, S_FIN
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sub_q, sub_d;
    logic [N-1:0]   m_q, m_d;
    logic           t_sign_q, t_sign_d;
    logic [N-1:0]   t_low_q, t_low_d;
    logic [N+1:0]   in_a_q, in_a_d;
    logic [N+1:0]   in_b_q, in_b_d;
    logic           subtract_q, subtract_d;
    logic [N-1:0]   result_q, result_d;
    logic           timeout_hit;

    assign timeout_hit = (cnt_q == CW'(TIMEOUT));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sub_q      <= 1'b0;
            m_q        <= '0;
            t_sign_q   <= 1'b0;
            t_low_q    <= '0;
            in_a_q     <= '0;
            in_b_q     <= '0;
            subtract_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sub_q      <= sub_d;
            m_q        <= m_d;
            t_sign_q   <= t_sign_d;
            t_low_q    <= t_low_d;
            in_a_q     <= in_a_d;
            in_b_q     <= in_b_d;
            subtract_q <= subtract_d;
            result_q   <= result_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ISSUE1;
            S_ISSUE1: begin state_d = S_WAIT1; cnt_d = '0; end
            S_WAIT1: begin
                if (add_bus.add_done)  state_d = S_ISSUE2;
                else if (timeout_hit)  state_d = S_IDLE;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            S_ISSUE2: begin state_d = S_WAIT2; cnt_d = '0; end
            S_WAIT2: begin
                if (add_bus.add_done)  state_d = S_FIN;
                else if (timeout_hit)  state_d = S_IDLE;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy              = (state_q != S_IDLE);
        done              = (state_q == S_FIN);
        add_bus.add_start = (state_q == S_ISSUE1) || (state_q == S_ISSUE2);
        err               = ((state_q == S_WAIT1) || (state_q == S_WAIT2))
                            && !add_bus.add_done && timeout_hit;
    end

    // Operands live in the adder-facing registers so they stay stable through each wait.
    always_comb begin
        sub_d      = sub_q;
        m_d        = m_q;
        t_sign_d   = t_sign_q;
        t_low_d    = t_low_q;
        in_a_d     = in_a_q;
        in_b_d     = in_b_q;
        subtract_d = subtract_q;
        result_d   = result_q;
        if (state_q == S_IDLE && start) begin
            sub_d      = op_sub;
            m_d        = in_m;
            in_a_d     = {2'b00, in_a};
            in_b_d     = {2'b00, in_b};
            subtract_d = op_sub;
        end
        if (state_q == S_WAIT1 && add_bus.add_done) begin
            t_sign_d   = add_bus.add_result[N+2];
            t_low_d    = add_bus.add_result[N-1:0];
            in_a_d     = add_bus.add_result[N+1:0];
            in_b_d     = {2'b00, m_q};
            subtract_d = ~sub_q;
        end
        // Add: keep t unless t-M stayed non-negative. Sub: add M back only on borrow.
        if (state_q == S_WAIT2 && add_bus.add_done) begin
            if (sub_q) result_d = t_sign_q ? add_bus.add_result[N-1:0] : t_low_q;
            else       result_d = add_bus.add_result[N+2] ? t_low_q : add_bus.add_result[N-1:0];
        end
    end

    assign result               = result_q;
    assign add_bus.add_subtract = subtract_q;
    assign add_bus.add_shift    = 1'b0;
    assign add_bus.add_in_a     = in_a_q;
    assign add_bus.add_in_b     = in_b_q;
endmodule
